// File: rtl/nibble_packer.sv
// Packs NIBBLES consecutive 4-bit nibbles (first nibble in the MSBs) into a word
// and queues finished words in a DEPTH-entry FIFO drained by valid/ready.
module nibble_packer #(
  parameter int unsigned NIBBLES = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [3:0]               in_nibble,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [4*NIBBLES-1:0]     out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(NIBBLES);

  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];

  logic          word_done;
  logic          pop;
  logic          full;
  logic          push_ok;
  logic [W-1:0]  word;

  always_comb begin
    word      = {acc_q[W-5:0], in_nibble};
    word_done = in_valid && !flush && (idx_q == IW'(NIBBLES - 1));
    pop       = (count_q != '0) && out_ready;
    full      = (count_q == CW'(DEPTH));
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    push_ok   = word_done && (!full || pop);

    idx_d      = idx_q;
    acc_d      = acc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_d      = mem_q;

    if (flush) begin
      idx_d = '0;
      acc_d = '0;
    end else if (in_valid) begin
      acc_d = word;
      idx_d = word_done ? '0 : idx_q + IW'(1);
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = word;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else if (word_done) begin
      overflow_d = 1'b1;
    end

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      acc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer: directed scenarios plus random traffic,
// all compared against a queue-based reference model of packer and FIFO.
module tb_nibble_packer;

  localparam int unsigned NIBBLES = 2;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned W       = 4 * NIBBLES;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;
  localparam int unsigned VW      = 1 + W + CW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [3:0]    in_nibble = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [W-1:0] mq[$];
  logic [3:0]   part[$];
  bit           movf = 0;

  nibble_packer #(.NIBBLES(NIBBLES), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_nibble(in_nibble),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] exp_vec();
    logic [W-1:0] d;
    d = (mq.size() > 0) ? mq[0] : '0;
    return {mq.size() > 0, d, CW'(mq.size()), movf};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {out_valid, out_valid ? out_data : W'(0), fifo_count, overflow};
  endfunction

  // Drive one cycle, advance the model across the edge, return at edge+1.
  task automatic drive(input bit v, input logic [3:0] n, input bit f, input bit r);
    bit pop, full;
    logic [W-1:0] w;
    in_valid = v; in_nibble = n; flush = f; out_ready = r;
    pop  = (mq.size() > 0) && r;
    full = (mq.size() == DEPTH);
    if (pop) void'(mq.pop_front());
    if (f) part.delete();
    else if (v) begin
      part.push_back(n);
      if (part.size() == NIBBLES) begin
        w = '0;
        foreach (part[i]) w = (w << 4) | W'(part[i]);
        if (!full || pop) mq.push_back(w);
        else movf = 1;
        part.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  // Raise rst between clock edges and leave it high; model cleared.
  task automatic assert_reset();
    in_valid = 0; flush = 0; out_ready = 0;
    #2 rst = 1'b1;
    #1;
    mq.delete(); part.delete(); movf = 0;
  endtask

  task automatic release_reset();
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({out_valid, out_data, fifo_count, overflow} !== '0) begin
      fails++;
      $display("FAIL reset_state got %h want 0", {out_valid, out_data, fifo_count, overflow});
    end
    release_reset();
    tests++;
    if (act_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_release got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    logic [6:0] s [4] = '{7'b1_0_1_1010, 7'b1_0_1_0101, 7'b0_0_1_0000, 7'b0_0_1_0000};
    for (int i = 0; i < 4; i++) begin
      drive(s[i][6], s[i][3:0], s[i][5], s[i][4]);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL basic[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b [3] = '{8'h12, 8'h34, 8'h56};
    for (int i = 0; i < 6; i++) begin
      drive(1, (i % 2 == 0) ? b[i/2][7:4] : b[i/2][3:0], 0, 0);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL backpressure_fill[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
    tests++;
    if (fifo_count !== 3 || out_data !== 8'h12) begin
      fails++;
      $display("FAIL backpressure_head got cnt=%0d data=%h want cnt=3 data=12", fifo_count, out_data);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 1);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL backpressure_drain[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++) begin
      drive(1, 4'h0, 0, 0);
      drive(1, 4'(k), 0, 0);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL overflow_fill[%0d] got %h want %h", k, act_vec(), exp_vec());
      end
    end
    tests++;
    if (fifo_count !== 4 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_flag got cnt=%0d ovf=%b want cnt=4 ovf=1", fifo_count, overflow);
    end
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL overflow_drain[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_full_push_pop();
    assert_reset();
    release_reset();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 4'(k), 0, 0);
      drive(1, 4'(k), 0, 0);
    end
    drive(1, 4'h5, 0, 0);
    drive(1, 4'h5, 0, 1);
    tests++;
    if (fifo_count !== 4 || overflow !== 1'b0 || act_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL full_push_pop got %h want %h", act_vec(), exp_vec());
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 1);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL full_push_pop_drain[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    // F, flush, nibble-with-flush, 3, C, idle, then flush on a completing edge
    logic [6:0] s [9] = '{7'b1_0_0_1111, 7'b0_1_0_0000, 7'b1_1_0_1001, 7'b1_0_0_0011,
                          7'b1_0_0_1100, 7'b0_0_1_0000, 7'b1_0_1_0001, 7'b1_1_1_0010,
                          7'b0_0_1_0000};
    for (int i = 0; i < 9; i++) begin
      drive(s[i][6], s[i][3:0], s[i][5], s[i][4]);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL flush[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) drive(1, 4'(k + 6), 0, 0);
    assert_reset();
    tests++;
    if ({out_valid, out_data, fifo_count, overflow} !== '0) begin
      fails++;
      $display("FAIL async_reset got %h want 0", {out_valid, out_data, fifo_count, overflow});
    end
    release_reset();
    drive(1, 4'h7, 0, 0);
    drive(1, 4'h8, 0, 0);
    tests++;
    if (act_vec() !== exp_vec() || out_data !== 8'h78) begin
      fails++;
      $display("FAIL async_reset_after got %h want %h", act_vec(), exp_vec());
    end
    drive(0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom % 4 != 0, 4'($urandom), $urandom % 16 == 0, $urandom % 3 == 0);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
